// File: rtl/cpu_clock_controller.sv
`default_nettype none
// ============================================================================
// cpu_clock_controller: halt/step/slow/fast clock-enable sequencer for the core
// Rev 1.0
// ============================================================================
module cpu_clock_controller #(
  parameter int DIV_SLOW = 5000000,
  parameter int DEBOUNCE = 1000000
) (
  input  logic        primitive_clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic        step_btn,
  input  logic        cpu_halt,
  input  logic        resume,
  output logic        clk_en,
  output logic        halted,
  output logic [1:0]  state,
  output logic [31:0] cycle_count
);

  localparam int DIV_W = (DIV_SLOW > 1) ? $clog2(DIV_SLOW) : 1;
  localparam int DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_SLOW - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_STEP = 2'b01,
    MODE_SLOW = 2'b10,
    MODE_FAST = 2'b11
  } mode_t;

  mode_t            mode_q;
  logic [DIV_W-1:0] div_cnt;
  logic [DB_W-1:0]  db_cnt;
  logic             s1;
  logic             s2;
  logic             db_level;
  logic             db_prev;
  logic             block;
  logic             db_rise;

  assign block   = cpu_halt | halted;
  assign db_rise = db_level & ~db_prev;
  assign state   = mode_q;

  always_ff @(posedge primitive_clk) begin
    if (rst) begin
      mode_q      <= MODE_HALT;
      div_cnt     <= '0;
      db_cnt      <= '0;
      s1          <= 1'b0;
      s2          <= 1'b0;
      db_level    <= 1'b0;
      db_prev     <= 1'b0;
      halted      <= 1'b0;
      clk_en      <= 1'b0;
      cycle_count <= '0;
    end else begin
      mode_q  <= mode_t'(mode);
      s1      <= step_btn;
      s2      <= s1;
      db_prev <= db_level;

      // Level only moves after DEBOUNCE consecutive disagreeing samples.
      if (s2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= s2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end

      if (cpu_halt) begin
        halted <= 1'b1;
      end else if (resume) begin
        halted <= 1'b0;
      end

      if ((mode_t'(mode) != mode_q) || resume) begin
        div_cnt <= '0;
      end else if ((mode_q == MODE_SLOW) && !block) begin
        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      end

      case (mode_q)
        MODE_FAST: clk_en <= !block;
        MODE_SLOW: clk_en <= (div_cnt == DIV_LAST) && !block;
        MODE_STEP: clk_en <= db_rise && !block;
        default:   clk_en <= 1'b0;
      endcase

      if (clk_en && (cycle_count != 32'hFFFF_FFFF)) begin
        cycle_count <= cycle_count + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_clock_controller.sv
`default_nettype none
// ============================================================================
// tb_cpu_clock_controller: scoreboard bench with a behavioural reference model
// Rev 1.0
// ============================================================================
module tb_cpu_clock_controller;

  localparam int DIV = 4;
  localparam int DB  = 8;

  logic        primitive_clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic        step_btn = 1'b0;
  logic        cpu_halt = 1'b0;
  logic        resume = 1'b0;
  logic        clk_en;
  logic        halted;
  logic [1:0]  state;
  logic [31:0] cycle_count;

  cpu_clock_controller #(.DIV_SLOW(DIV), .DEBOUNCE(DB)) dut (
    .primitive_clk(primitive_clk),
    .rst(rst),
    .mode(mode),
    .step_btn(step_btn),
    .cpu_halt(cpu_halt),
    .resume(resume),
    .clk_en(clk_en),
    .halted(halted),
    .state(state),
    .cycle_count(cycle_count)
  );

  always #5 primitive_clk = ~primitive_clk;

  typedef struct packed {
    logic        en;
    logic        hlt;
    logic [1:0]  st;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model state: behaviour described by history and elapsed time.
  logic [1:0]  m_mode = 2'b00;
  bit          m_halt = 1'b0;
  bit          m_en = 1'b0;
  logic [31:0] m_cnt = 32'd0;
  longint      ticks = 0;      // eligible slow cycles since last restart
  bit          db = 1'b0;      // debounced button level
  bit          rose_last = 1'b0;
  bit          raw_hist[$];    // button samples taken at past edges, newest last

  task automatic model_edge(input bit r, input logic [1:0] m, input bit b,
                            input bit h, input bit rs);
    bit blk;
    bit s2v;
    bit flip;
    bit en_n;
    int n;
    if (r) begin
      m_mode = 2'b00; m_halt = 1'b0; m_en = 1'b0; m_cnt = 32'd0;
      ticks = 0; db = 1'b0; rose_last = 1'b0;
      raw_hist.delete();
    end else begin
      blk  = h | m_halt;
      n    = raw_hist.size();
      // The synchronised button seen at this edge was sampled two edges ago;
      // the level flips once DB successive synchronised values disagree with it.
      flip = 1'b1;
      for (int k = 2; k <= DB + 1; k++) begin
        s2v = (n >= k) ? raw_hist[n-k] : 1'b0;
        if (s2v == db) flip = 1'b0;
      end
      case (m_mode)
        2'b11:   en_n = !blk;
        2'b10:   en_n = ((ticks % DIV) == DIV - 1) && !blk;
        2'b01:   en_n = rose_last && !blk;
        default: en_n = 1'b0;
      endcase
      if (m_en && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 32'd1;
      if ((m != m_mode) || rs) ticks = 0;
      else if ((m_mode == 2'b10) && !blk) ticks = ticks + 1;
      if (h) m_halt = 1'b1;
      else if (rs) m_halt = 1'b0;
      rose_last = flip && !db;
      if (flip) db = !db;
      m_en   = en_n;
      m_mode = m;
      raw_hist.push_back(b);
      if (raw_hist.size() > DB + 2) void'(raw_hist.pop_front());
    end
    sb.push_back({m_en, m_halt, m_mode, m_cnt});
  endtask

  task automatic cyc(input bit r, input logic [1:0] m, input bit b,
                     input bit h, input bit rs, input bit frc = 1'b0);
    @(negedge primitive_clk);
    if (frc) begin
      force dut.cycle_count = 32'hFFFF_FFFE;
      #1;
      release dut.cycle_count;
      m_cnt = 32'hFFFF_FFFE;
    end
    rst      = r;
    mode     = m;
    step_btn = b;
    cpu_halt = h;
    resume   = rs;
    model_edge(r, m, b, h, rs);
  endtask

  task automatic run(input int n, input logic [1:0] m, input bit b);
    for (int i = 0; i < n; i++) cyc(1'b0, m, b, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge primitive_clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ((clk_en === e.en) && (halted === e.hlt) && (state === e.st) &&
            (cycle_count === e.cnt)) begin
          passed++;
        end else begin
          $display("FAIL outputs t=%0t got en=%0b halted=%0b state=%0d count=%0h expected en=%0b halted=%0b state=%0d count=%0h",
                   $time, clk_en, halted, state, cycle_count, e.en, e.hlt, e.st, e.cnt);
        end
      end
    end
  end

  initial begin : stimulus
    int         len;
    logic [1:0] rm;
    bit         rb;

    // Reset then full-speed run
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    run(15, 2'b11, 1'b0);

    // Slow run, then drop to halt mid-count
    run(22, 2'b10, 1'b0);
    run(2, 2'b10, 1'b0);
    run(10, 2'b00, 1'b0);

    // Bouncing button in step mode, then clean hold, release, re-press
    for (int i = 0; i < 30; i++) cyc(1'b0, 2'b01, bit'((i / 3) % 2), 1'b0, 1'b0);
    run(20, 2'b01, 1'b1);
    run(20, 2'b01, 1'b0);
    run(20, 2'b01, 1'b1);
    run(20, 2'b01, 1'b0);

    // Halt and resume at full speed
    run(20, 2'b11, 1'b0);
    cyc(1'b0, 2'b11, 1'b0, 1'b1, 1'b0);
    run(5, 2'b11, 1'b0);
    cyc(1'b0, 2'b11, 1'b0, 1'b1, 1'b1);
    run(5, 2'b11, 1'b0);
    cyc(1'b0, 2'b11, 1'b0, 1'b0, 1'b1);
    run(6, 2'b11, 1'b0);

    // Halt and resume in slow mode
    run(6, 2'b10, 1'b0);
    cyc(1'b0, 2'b10, 1'b0, 1'b1, 1'b0);
    run(4, 2'b10, 1'b0);
    cyc(1'b0, 2'b10, 1'b0, 1'b0, 1'b1);
    run(10, 2'b10, 1'b0);

    // Step press discarded while halted, not replayed after resume
    cyc(1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
    run(20, 2'b01, 1'b1);
    cyc(1'b0, 2'b01, 1'b1, 1'b0, 1'b1);
    run(10, 2'b01, 1'b1);
    run(20, 2'b01, 1'b0);
    run(20, 2'b01, 1'b1);

    // Randomised mix of modes, button holds, halts, resumes and one reset
    for (int s = 0; s < 50; s++) begin
      len = $urandom_range(2, 16);
      rm  = 2'($urandom_range(0, 3));
      rb  = bit'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
        cyc((s == 25) && (i == 0), rm, rb,
            bit'($urandom_range(0, 19) == 0), bit'($urandom_range(0, 7) == 0));
      end
    end
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

    // Saturation of the enable counter, then reset mid-run
    run(3, 2'b00, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    run(6, 2'b11, 1'b0);
    cyc(1'b1, 2'b11, 1'b1, 1'b1, 1'b0);
    run(3, 2'b11, 1'b0);

    @(posedge primitive_clk);
    #2;
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain pending=%0d required=0", sb.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
